// File: rtl/acl_cmd_ctrl.sv
// acl_cmd_ctrl: turns eight ASCII hex characters from the UART into a 32-bit
// command, runs the 3-byte SPI transaction it describes and answers over the
// UART TX byte interface. Command word: [31:24] mode (00 write, 01 read),
// [23:16] SPI instruction, [15:8] register address, [7:0] write data.
//
// state   | meaning
// --------+------------------------------------------------------------------
// COLLECT | gather hex characters into the command word
// SEND0   | spi_start with the instruction byte
// WAIT0   | wait for spi_done of the instruction byte
// SEND1   | spi_start with the register address
// WAIT1   | wait for spi_done of the address byte
// SEND2   | spi_start with write data (or 0x00 for read), spi_last set
// WAIT2   | wait for spi_done, capture spi_rx
// REPLY0  | send ACK_CHAR (write) or high read nibble in ASCII
// REPLY1  | send low read nibble in ASCII
// ERR     | send ERR_CHAR for a rejected command
module acl_cmd_ctrl #(
    parameter int unsigned IDLE_TIMEOUT = 1000000,
    parameter logic [7:0]  ACK_CHAR     = 8'h4B,
    parameter logic [7:0]  ERR_CHAR     = 8'h3F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       spi_start,
    output logic [7:0] spi_tx,
    output logic       spi_last,
    input  logic       spi_done,
    input  logic [7:0] spi_rx,
    output logic       busy,
    output logic       cmd_err
);

    localparam int TW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMR_LAST = TW'(IDLE_TIMEOUT - 1);

    typedef enum logic [3:0] {
        COLLECT, SEND0, WAIT0, SEND1, WAIT1, SEND2, WAIT2, REPLY0, REPLY1, ERR
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     cmd_q, cmd_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [7:0]      rd_q, rd_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            spi_start_q, spi_start_d;
    logic [7:0]      spi_tx_q, spi_tx_d;
    logic            spi_last_q, spi_last_d;
    logic            busy_q, busy_d;
    logic            cmd_err_q, cmd_err_d;
    logic [4:0]      dec;

    // {valid, nibble}; 'A'-'F' and 'a'-'f' share the low bits 1..6
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic [7:0] hex_encode(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : {4'h4, n - 4'd9};
    endfunction

    // Next-state logic; outputs are derived from the next state so they
    // leave the flops already aligned with the state they belong to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        tmr_d     = tmr_q;
        rd_d      = rd_q;
        cmd_err_d = 1'b0;
        dec       = hex_decode(rx_data);

        case (state_q)
            COLLECT: begin
                if (rx_valid) begin
                    if (dec[4]) begin
                        cmd_d = {cmd_q[27:0], dec[3:0]};
                        tmr_d = '0;
                        if (cnt_q == 3'd7) begin
                            cnt_d = 3'd0;
                            if (cmd_d[31:25] == 7'd0) begin
                                state_d = SEND0;
                            end else begin
                                state_d   = ERR;
                                cmd_err_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end else if (!(cnt_q == 3'd0 && (rx_data == 8'h0D || rx_data == 8'h0A))) begin
                        cnt_d     = 3'd0;
                        cmd_d     = 32'd0;
                        tmr_d     = '0;
                        state_d   = ERR;
                        cmd_err_d = 1'b1;
                    end
                end else if (IDLE_TIMEOUT != 0 && cnt_q != 3'd0) begin
                    if (tmr_q == TMR_LAST) begin
                        cnt_d = 3'd0;
                        cmd_d = 32'd0;
                        tmr_d = '0;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            SEND0:   state_d = WAIT0;
            WAIT0:   if (spi_done) state_d = SEND1;
            SEND1:   state_d = WAIT1;
            WAIT1:   if (spi_done) state_d = SEND2;
            SEND2:   state_d = WAIT2;
            WAIT2: begin
                if (spi_done) begin
                    rd_d    = spi_rx;
                    state_d = REPLY0;
                end
            end
            REPLY0:  if (tx_ready) state_d = cmd_q[24] ? REPLY1 : COLLECT;
            REPLY1:  if (tx_ready) state_d = COLLECT;
            ERR:     if (tx_ready) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase

        spi_start_d = (state_d == SEND0) || (state_d == SEND1) || (state_d == SEND2);
        spi_last_d  = (state_d == SEND2);
        case (state_d)
            SEND0:   spi_tx_d = cmd_d[23:16];
            SEND1:   spi_tx_d = cmd_d[15:8];
            SEND2:   spi_tx_d = cmd_d[24] ? 8'h00 : cmd_d[7:0];
            default: spi_tx_d = 8'h00;
        endcase

        tx_valid_d = (state_d == REPLY0) || (state_d == REPLY1) || (state_d == ERR);
        case (state_d)
            REPLY0:  tx_data_d = cmd_d[24] ? hex_encode(rd_d[7:4]) : ACK_CHAR;
            REPLY1:  tx_data_d = hex_encode(rd_d[3:0]);
            ERR:     tx_data_d = ERR_CHAR;
            default: tx_data_d = 8'h00;
        endcase

        busy_d = (state_d != COLLECT);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= COLLECT;
            cnt_q       <= 3'd0;
            cmd_q       <= 32'd0;
            tmr_q       <= '0;
            rd_q        <= 8'h00;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            spi_start_q <= 1'b0;
            spi_tx_q    <= 8'h00;
            spi_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            tmr_q       <= tmr_d;
            rd_q        <= rd_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            spi_start_q <= spi_start_d;
            spi_tx_q    <= spi_tx_d;
            spi_last_q  <= spi_last_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign spi_start = spi_start_q;
    assign spi_tx    = spi_tx_q;
    assign spi_last  = spi_last_q;
    assign busy      = busy_q;
    assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_acl_cmd_ctrl.sv
// Bench for acl_cmd_ctrl: SPI slave and UART sink models record what the DUT
// does; a character-level command model predicts what it should do.
module tb_acl_cmd_ctrl;

    localparam int unsigned TO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       spi_start;
    logic [7:0] spi_tx;
    logic       spi_last;
    logic       spi_done = 1'b0;
    logic [7:0] spi_rx = 8'h00;
    logic       busy;
    logic       cmd_err;

    acl_cmd_ctrl #(.IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .spi_start(spi_start), .spi_tx(spi_tx), .spi_last(spi_last),
        .spi_done(spi_done), .spi_rx(spi_rx),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [8:0] obs_spi[$];
    logic [8:0] exp_spi[$];
    logic [7:0] obs_tx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] stim[$];
    int         obs_err = 0;
    int         err0 = 0;
    int         exp_err = 0;
    logic [7:0] rx3_cur = 8'h00;
    bit         tx_hold = 1'b0;
    int         slave_min = 0;

    // UART TX sink and cmd_err counter
    always @(negedge clk) begin
        if (rst) begin
            if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
            if (cmd_err) obs_err++;
        end
    end

    // tx_ready: random acceptance unless a test holds it off
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            tx_ready = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // SPI slave: record each start, answer with spi_done after a random delay
    initial begin
        logic last_b;
        forever begin
            @(negedge clk);
            if (spi_start) begin
                obs_spi.push_back({spi_last, spi_tx});
                last_b = spi_last;
                repeat (slave_min + int'($urandom_range(0, 4))) @(posedge clk);
                @(posedge clk); #1;
                spi_done = 1'b1;
                spi_rx   = last_b ? rx3_cur : 8'($urandom);
                @(posedge clk); #1;
                spi_done = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int nib_of(input logic [7:0] c);
        if (c >= 8'd48 && c <= 8'd57)  return int'(c) - 48;
        if (c >= 8'd65 && c <= 8'd70)  return int'(c) - 55;
        if (c >= 8'd97 && c <= 8'd102) return int'(c) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] up_hex(input int n);
        return (n < 10) ? 8'(48 + n) : 8'(55 + n);
    endfunction

    // Command model: walks the characters with plain arithmetic and appends
    // the SPI bytes, reply bytes and rejections the command should produce.
    task automatic model_stim();
        longint unsigned val;
        longint unsigned mode;
        int digits;
        int n;
        val = 0;
        digits = 0;
        foreach (stim[i]) begin
            n = nib_of(stim[i]);
            if (n >= 0) begin
                val = val * 16 + longint'(n);
                digits++;
                if (digits == 8) begin
                    mode = val / 16777216;
                    if (mode <= 1) begin
                        exp_spi.push_back({1'b0, 8'((val / 65536) % 256)});
                        exp_spi.push_back({1'b0, 8'((val / 256) % 256)});
                        if (mode == 0) begin
                            exp_spi.push_back({1'b1, 8'(val % 256)});
                            exp_tx.push_back(8'h4B);
                        end else begin
                            exp_spi.push_back({1'b1, 8'h00});
                            exp_tx.push_back(up_hex(int'(rx3_cur) / 16));
                            exp_tx.push_back(up_hex(int'(rx3_cur) % 16));
                        end
                    end else begin
                        exp_err++;
                        exp_tx.push_back(8'h3F);
                    end
                    digits = 0;
                    val = 0;
                end
            end else if (!((stim[i] == 8'h0D || stim[i] == 8'h0A) && digits == 0)) begin
                exp_err++;
                exp_tx.push_back(8'h3F);
                digits = 0;
                val = 0;
            end
        end
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    task automatic clear_obs();
        obs_spi.delete();
        obs_tx.delete();
        exp_spi.delete();
        exp_tx.delete();
        exp_err = 0;
        err0 = obs_err;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_stim(input int gapmax);
        foreach (stim[i]) begin
            send_byte(stim[i]);
            if (i != stim.size() - 1) repeat ($urandom_range(0, gapmax)) @(posedge clk);
        end
    endtask

    task automatic wait_idle(output bit expired);
        int n = 0;
        while ((busy || tx_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        expired = (n >= 600);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({tx_data, tx_valid, spi_start, spi_tx, spi_last, busy, cmd_err} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {tx_data, tx_valid, spi_start, spi_tx, spi_last, busy, cmd_err});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: busy=%b tx_valid=%b required 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_write();
        bit exp_to;
        clear_obs();
        stim.delete();
        push_str("000A2057");
        model_stim();
        send_stim(3);
        total++;
        if (spi_start !== 1'b1 || spi_tx !== 8'h0A) begin
            bad++;
            $display("FAIL write_first_start: start=%b tx=%h required 1 0a", spi_start, spi_tx);
        end
        wait_idle(exp_to);
        total++;
        if (exp_to) begin bad++; $display("FAIL write_idle: busy=%b required 0", busy); end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL write_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL write_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL write_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL write_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
        total++;
        if (obs_err - err0 != exp_err) begin bad++; $display("FAIL write_err: got %0d required %0d", obs_err - err0, exp_err); end
    endtask

    task automatic test_read();
        bit exp_to;
        clear_obs();
        rx3_cur = 8'hAA;
        stim.delete();
        push_str("010b2000");
        model_stim();
        send_stim(3);
        wait_idle(exp_to);
        total++;
        if (exp_to) begin bad++; $display("FAIL read_idle: busy=%b required 0", busy); end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL read_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL read_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL read_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL read_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_errors();
        bit exp_to;
        string cmds[3];
        cmds[0] = "00G";
        cmds[1] = "020B2000";
        cmds[2] = "000A2057";
        clear_obs();
        foreach (cmds[k]) begin
            stim.delete();
            push_str(cmds[k]);
            model_stim();
            send_stim(2);
            wait_idle(exp_to);
            total++;
            if (exp_to) begin bad++; $display("FAIL err_idle%0d: busy=%b required 0", k, busy); end
        end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL err_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL err_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL err_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL err_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
        total++;
        if (obs_err - err0 != exp_err) begin bad++; $display("FAIL err_pulses: got %0d required %0d", obs_err - err0, exp_err); end
    endtask

    task automatic test_backpressure();
        bit exp_to;
        int n;
        clear_obs();
        rx3_cur = 8'hAA;
        tx_hold = 1'b1;
        stim.delete();
        push_str("010b2000");
        model_stim();
        send_stim(2);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
        n = 0;
        while (!tx_valid && n < 200) begin @(negedge clk); n++; end
        total++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
            bad++; $display("FAIL bp_first: valid=%b data=%h required 1 41", tx_valid, tx_data);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            total++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
                bad++; $display("FAIL bp_hold cycle %0d: valid=%b data=%h required 1 41", i, tx_valid, tx_data);
            end
        end
        tx_hold = 1'b0;
        wait_idle(exp_to);
        stim.delete();
        push_str("000A2057");
        model_stim();
        send_stim(2);
        wait_idle(exp_to);
        total++;
        if (exp_to) begin bad++; $display("FAIL bp_idle: busy=%b required 0", busy); end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL bp_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL bp_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL bp_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL bp_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_timeout();
        bit exp_to;
        clear_obs();
        stim.delete();
        push_str("000A");
        send_stim(2);
        repeat (TO + 1) @(posedge clk);
        total++;
        if (busy !== 1'b0 || obs_tx.size() != 0 || obs_err != err0) begin
            bad++; $display("FAIL to_silent: busy=%b tx=%0d err=%0d required 0 0 0", busy, obs_tx.size(), obs_err - err0);
        end
        stim.delete();
        push_str("000A2057");
        model_stim();
        send_stim(2);
        wait_idle(exp_to);
        // a long gap that stays below the timeout must not discard digits
        stim.delete();
        push_str("000A");
        send_stim(2);
        repeat (TO - 40) @(posedge clk);
        stim.delete();
        push_str("2057");
        send_stim(2);
        stim.delete();
        push_str("000A2057");
        model_stim();
        wait_idle(exp_to);
        total++;
        if (exp_to) begin bad++; $display("FAIL to_idle: busy=%b required 0", busy); end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL to_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL to_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL to_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL to_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_reset_midop();
        bit exp_to;
        int n;
        clear_obs();
        slave_min = 12;
        stim.delete();
        push_str("010B2000");
        send_stim(2);
        n = 0;
        while (obs_spi.size() < 2 && n < 200) begin @(negedge clk); n++; end
        @(posedge clk); #3;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL midop_busy: got %b required 1", busy); end
        rst = 1'b0;
        #1;
        total++;
        if ({tx_data, tx_valid, spi_start, spi_tx, spi_last, busy, cmd_err} !== 21'd0) begin
            bad++;
            $display("FAIL midop_async_reset: got %h required 0",
                     {tx_data, tx_valid, spi_start, spi_tx, spi_last, busy, cmd_err});
        end
        repeat (25) @(negedge clk);
        rst = 1'b1;
        slave_min = 0;
        clear_obs();
        rx3_cur = 8'($urandom);
        stim.delete();
        push_str("010B2000");
        model_stim();
        send_stim(2);
        wait_idle(exp_to);
        total++;
        if (exp_to) begin bad++; $display("FAIL midop_idle: busy=%b required 0", busy); end
        total++;
        if (obs_spi.size() != exp_spi.size()) begin
            bad++; $display("FAIL midop_spi_count: got %0d required %0d", obs_spi.size(), exp_spi.size());
        end else foreach (exp_spi[i]) begin
            total++;
            if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL midop_spi%0d: got %h required %h", i, obs_spi[i], exp_spi[i]); end
        end
        total++;
        if (obs_tx.size() != exp_tx.size()) begin
            bad++; $display("FAIL midop_tx_count: got %0d required %0d", obs_tx.size(), exp_tx.size());
        end else foreach (exp_tx[i]) begin
            total++;
            if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL midop_tx%0d: got %h required %h", i, obs_tx[i], exp_tx[i]); end
        end
    endtask

    task automatic test_random();
        bit exp_to;
        logic [7:0]  bad_set[9];
        logic [31:0] v;
        logic [7:0]  mode;
        int r, pos, nb;
        bad_set = '{8'h47, 8'h7A, 8'h20, 8'h0D, 8'h2F, 8'h3A, 8'h40, 8'h60, 8'h67};
        for (int it = 0; it < 30; it++) begin
            clear_obs();
            rx3_cur = 8'($urandom);
            r = int'($urandom_range(0, 9));
            mode = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'($urandom_range(2, 255));
            v = {mode, 24'($urandom)};
            pos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : 8;
            stim.delete();
            if ($urandom_range(0, 4) == 0) stim.push_back($urandom_range(0, 1) ? 8'h0D : 8'h0A);
            for (int k = 0; k < pos; k++) begin
                nb = int'((v >> (28 - 4 * k)) & 32'hF);
                if (nb < 10) stim.push_back(8'(48 + nb));
                else stim.push_back(8'(($urandom_range(0, 1) ? 87 : 55) + nb));
            end
            if (pos < 8) stim.push_back(bad_set[$urandom_range(0, 8)]);
            model_stim();
            send_stim(3);
            wait_idle(exp_to);
            total++;
            if (exp_to) begin bad++; $display("FAIL rand_idle it%0d: busy=%b required 0", it, busy); end
            total++;
            if (obs_spi.size() != exp_spi.size()) begin
                bad++; $display("FAIL rand_spi_count it%0d: got %0d required %0d", it, obs_spi.size(), exp_spi.size());
            end else foreach (exp_spi[i]) begin
                total++;
                if (obs_spi[i] !== exp_spi[i]) begin bad++; $display("FAIL rand_spi it%0d b%0d: got %h required %h", it, i, obs_spi[i], exp_spi[i]); end
            end
            total++;
            if (obs_tx.size() != exp_tx.size()) begin
                bad++; $display("FAIL rand_tx_count it%0d: got %0d required %0d", it, obs_tx.size(), exp_tx.size());
            end else foreach (exp_tx[i]) begin
                total++;
                if (obs_tx[i] !== exp_tx[i]) begin bad++; $display("FAIL rand_tx it%0d b%0d: got %h required %h", it, i, obs_tx[i], exp_tx[i]); end
            end
            total++;
            if (obs_err - err0 != exp_err) begin bad++; $display("FAIL rand_err it%0d: got %0d required %0d", it, obs_err - err0, exp_err); end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_backpressure();
        test_timeout();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acl_cmd_ctrl.md
Name: acl_cmd_ctrl

Overview:
Command sequencer between the UART byte interface and the SPI byte master of the accelerometer path. It collects 8 ASCII hex characters into a 32-bit command and runs the matching 3-byte SPI transaction. It then returns a status or read-data reply as ASCII over the UART TX byte interface. It owns the SPI master and the UART TX; no other block drives them.

Parameters:
IDLE_TIMEOUT, 1000000, cycles of inactivity mid-command before the partial command is discarded (0 = disabled)
ACK_CHAR, 8'h4B, reply byte for a completed write ('K')
ERR_CHAR, 8'h3F, reply byte for a bad character or unknown mode ('?')

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received UART byte
rx_data  in  8  received byte
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  UART TX can accept; transfer occurs when tx_valid & tx_ready on a clk edge
spi_start  out  1  one-cycle pulse: SPI master sends spi_tx
spi_tx  out  8  byte to shift out
spi_last  out  1  qualifies spi_start: SPI master raises CSN after this byte
spi_done  in  1  one-cycle pulse: byte finished; spi_rx valid this cycle
spi_rx  in  8  byte shifted in on MISO
busy  out  1  high in any state other than COLLECT
cmd_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (rst=0, asynchronous): state COLLECT, digit count 0, command register 0, timeout counter 0. All outputs 0 (tx_data=0, spi_tx=0). Reset mid-transaction abandons it immediately; the SPI master's own reset releases CSN.
- Command word: [31:24] mode (0x00 write, 0x01 read), [23:16] SPI instruction, [15:8] register address, [7:0] data (ignored for read).
- COLLECT: on rx_valid, '0'-'9', 'A'-'F' and 'a'-'f' decode to a nibble. The command shifts left by 4 and the nibble enters [3:0]; the first character is the MSB nibble. Digit count increments.
  - On the 8th digit: next state is SEND0 if the mode is 00/01. Otherwise go to ERR and pulse cmd_err.
  - Non-hex character: discard the partial command, set count to 0, go to ERR, pulse cmd_err. Bytes 0x0D/0x0A with count 0 are ignored silently.
- Timeout: the counter runs only in COLLECT with count>0 and clears on each accepted byte. When it reaches IDLE_TIMEOUT, count resets to 0 silently (no reply).
- rx_valid outside COLLECT: byte dropped, no effect.
- SEND0/1/2: pulse spi_start for exactly 1 cycle, with spi_tx = instruction, address, then data (write) or 0x00 (read). spi_last=1 only with the third byte. Then wait in the matching WAIT state for spi_done.
  - The first spi_start occurs the cycle after the 8th digit is registered.
  - Each following start occurs the cycle after spi_done.
  - spi_done in a SEND state or in COLLECT is ignored.
- Read: spi_rx is captured on the third spi_done. Reply is two uppercase hex ASCII characters, high nibble first.
- Write: reply is the single byte ACK_CHAR.
- REPLY states: drive tx_valid=1 with tx_data stable until a clk edge with tx_ready=1, then advance. tx_valid drops the cycle after the last byte is accepted, and the state returns to COLLECT with count 0.
- ERR: send ERR_CHAR with the same handshake, then return to COLLECT.
- No output combinationally depends on inputs; all outputs are registered.

Test Plan:
- Write command: send "000A2057" → SPI bytes 0x0A, 0x20, 0x57 with spi_last only on 0x57. Then tx_data 0x4B once; busy returns to 0.
- Read command: send "010b2000" (lowercase b), spi_rx=0xAA on the third byte → SPI bytes 0x0B, 0x20, 0x00. TX 0x41, 0x41.
- Bad character / unknown mode: send "00G" → cmd_err pulse and TX 0x3F, no spi_start. Send "020B2000" → cmd_err and 0x3F, no SPI activity. Then "000A2057" is accepted normally.
- Backpressure and dropped input: hold tx_ready=0 for 50 cycles during the read reply → tx_valid and tx_data=0x41 stay stable. Extra rx bytes sent while busy are dropped and do not corrupt the next command.
- Timeout (IDLE_TIMEOUT=100): send "000A", idle 101 cycles, then "000A2057" → exactly one SPI transaction with bytes 0x0A, 0x20, 0x57.
- Reset mid-op: assert rst low during WAIT1 → all outputs 0 asynchronously. After release, a fresh "010B2000" completes correctly.
